mem_port: RTL and testbench

Bus interface between the multicycle controller/datapath and an external memory with a valid/ready handshake. It turns the controller's single-cycle read and write requests (instruction fetch, load, store) into handshaked bus transactions and holds the controller with `stall` until each transaction completes. It sits directly downstream of the controller's `AdrSrc`/`MemW`/`IRWrite` decisions and returns read data to the instruction register and data register path.

---
 rtl/mem_port.sv | 89 ++++++++
 tb/tb_mem_port.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port.sv
// mem_port: valid/ready bus master that stalls the multicycle controller for each fetch, load or store.
// Optional ISSUE-state watchdog enabled by defining MEM_PORT_TIMEOUT_EN.
module mem_port #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_req,
    input  logic          wr_req,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          stall,
    output logic          done,
    output logic          bus_valid,
    output logic          bus_we,
    output logic [AW-1:0] bus_adr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ready,
    input  logic [DW-1:0] bus_rdata,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state_q, state_d;
    logic          bus_valid_q, bus_valid_d, bus_we_q, bus_we_d, err_q, err_d;
    logic [AW-1:0] bus_adr_q, bus_adr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d, rdata_q, rdata_d;
    logic          req, accept, abort;

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Abort on the cycle the wait count would reach TIMEOUT
    assign abort = state_q == ISSUE && !bus_ready && cnt_q == CW'(TIMEOUT - 1);
    assign cnt_d = (state_q == ISSUE && !bus_ready) ? cnt_q + CW'(1) : '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
`else
    logic unused_timeout;
    assign abort          = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        req         = rd_req | wr_req;
        accept      = state_q == IDLE && req;
        state_d     = (state_q == IDLE)  ? (req ? ISSUE : IDLE) :
                      (state_q == ISSUE) ? ((bus_ready || abort) ? DONE : ISSUE) : IDLE;
        bus_valid_d = state_d == ISSUE;
        bus_we_d    = accept ? wr_req : bus_we_q;
        bus_adr_d   = accept ? adr    : bus_adr_q;
        bus_wdata_d = accept ? wdata  : bus_wdata_q;
        rdata_d     = (state_q == ISSUE && bus_ready && !bus_we_q) ? bus_rdata :
                      (abort && !bus_we_q) ? '1 : rdata_q;
        err_d       = err_q | abort;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_adr_q   <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_adr_q   <= bus_adr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end

    assign stall     = accept || state_q == ISSUE;
    assign done      = state_q == DONE;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_adr   = bus_adr_q;
    assign bus_wdata = bus_wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port: randomized transaction-level check of mem_port against a request/latency model.
// Define MEM_PORT_TIMEOUT_EN for both files to exercise the watchdog abort.
module tb_mem_port;
    logic        clk, reset, rd_req, wr_req, bus_ready;
    logic [31:0] adr, wdata, bus_rdata;
    logic [31:0] rdata, bus_adr, bus_wdata;
    logic        stall, done, bus_valid, bus_we, err;
    int          tests = 0, fails = 0;
    logic [31:0] exp_rdata = 0;

    mem_port dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .adr(adr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .done(done), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_adr(bus_adr), .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Drives one request (held through DONE) and measures the bus/controller side over its lifetime.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int waits,
                           output int nvalid, output int nstall, output int ndone,
                           output logic we_seen, output logic [31:0] adr_seen,
                           output logic [31:0] wd_seen, output logic stable);
        int extra;
        rd_req = rd; wr_req = wr; adr = a; wdata = wd; bus_ready = 0; bus_rdata = $urandom;
        nvalid = 0; nstall = 0; ndone = 0; stable = 1; extra = 0;
        we_seen = 0; adr_seen = 0; wd_seen = 0;
        for (int c = 0; c < 200 && extra < 4; c++) begin
            #1;
            if (stall) nstall++;
            if (bus_valid) begin
                if (nvalid == 0) begin
                    we_seen = bus_we; adr_seen = bus_adr; wd_seen = bus_wdata;
                end else if (bus_we !== we_seen || bus_adr !== adr_seen || bus_wdata !== wd_seen)
                    stable = 0;
                nvalid++;
            end
            if (done) ndone++;
            bus_ready = bus_valid ? (nvalid == waits + 1) : 1'($urandom % 2);
            bus_rdata = (bus_valid && bus_ready) ? rdat : $urandom;
            if (ndone > 0) extra++;
            @(posedge clk); #1;
            if (extra > 0) begin rd_req = 0; wr_req = 0; end
        end
        bus_ready = 0;
    endtask

    task automatic test_reset;
        reset = 0; rd_req = 0; wr_req = 0; adr = $urandom; wdata = $urandom;
        bus_ready = 1'($urandom % 2); bus_rdata = $urandom;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus_valid !== 0 || bus_we !== 0 || done !== 0 || stall !== 0) begin
            fails++; $display("FAIL reset_ctrl: valid=%b we=%b done=%b stall=%b, want 0000", bus_valid, bus_we, done, stall);
        end
        tests++; if (rdata !== 0 || bus_adr !== 0 || bus_wdata !== 0 || err !== 0) begin
            fails++; $display("FAIL reset_data: rdata=%h adr=%h wdata=%h err=%b, want zeros", rdata, bus_adr, bus_wdata, err);
        end
        reset = 1; bus_ready = 0;
        @(posedge clk); #1;
        tests++; if (bus_valid !== 0 || done !== 0 || stall !== 0) begin
            fails++; $display("FAIL reset_idle: valid=%b done=%b stall=%b, want 000", bus_valid, done, stall);
        end
    endtask

    task automatic test_read;
        int nv, ns, nd; logic we, st; logic [31:0] a, wd;
        run_txn(1, 0, 32'h40, $urandom, 32'h12345678, 0, nv, ns, nd, we, a, wd, st);
        exp_rdata = 32'h12345678;
        tests++; if (nv !== 1 || we !== 0 || a !== 32'h40) begin
            fails++; $display("FAIL read_bus: valid_cycles=%0d we=%b adr=%h, want 1 0 00000040", nv, we, a);
        end
        tests++; if (ns !== 2 || nd !== 1) begin
            fails++; $display("FAIL read_stall: stall=%0d done=%0d, want 2 1", ns, nd);
        end
        tests++; if (rdata !== exp_rdata) begin
            fails++; $display("FAIL read_data: rdata=%h, want %h", rdata, exp_rdata);
        end
    endtask

    task automatic test_write_wait;
        int nv, ns, nd; logic we, st; logic [31:0] a, wd;
        run_txn(0, 1, 32'h80, 32'hA5A5A5A5, $urandom, 3, nv, ns, nd, we, a, wd, st);
        tests++; if (nv !== 4 || !st || we !== 1 || a !== 32'h80 || wd !== 32'hA5A5A5A5) begin
            fails++; $display("FAIL write_bus: valid=%0d stable=%b we=%b adr=%h wd=%h, want 4 1 1 00000080 a5a5a5a5", nv, st, we, a, wd);
        end
        tests++; if (ns !== 5 || nd !== 1 || rdata !== exp_rdata) begin
            fails++; $display("FAIL write_stall: stall=%0d done=%0d rdata=%h, want 5 1 %h", ns, nd, rdata, exp_rdata);
        end
    endtask

    task automatic test_both;
        int nv, ns, nd; logic we, st; logic [31:0] a, wd, w;
        w = $urandom;
        run_txn(1, 1, 32'h100, w, $urandom, 1, nv, ns, nd, we, a, wd, st);
        tests++; if (we !== 1 || wd !== w || nv !== 2 || nd !== 1 || rdata !== exp_rdata) begin
            fails++; $display("FAIL both_req: we=%b wd=%h valid=%0d done=%0d rdata=%h, want 1 %h 2 1 %h", we, wd, w, nv, nd, rdata, exp_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int nv = 0, nd = 0;
        rd_req = 1; wr_req = 0; adr = $urandom; bus_ready = 1; bus_rdata = 32'hCAFEF00D;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (bus_valid) nv++;
            if (done) nd++;
            @(posedge clk); #1;
        end
        rd_req = 0; bus_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_rdata = 32'hCAFEF00D;
        // a held request costs 3 cycles per transaction: 9 cycles -> 3 transactions
        tests++; if (nv !== 3 || nd !== 3 || rdata !== exp_rdata) begin
            fails++; $display("FAIL back_to_back: valid=%0d done=%0d rdata=%h, want 3 3 %h", nv, nd, rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_mid;
        int nv, ns, nd, ndone_rst = 0; logic we, st; logic [31:0] a, wd, r;
        rd_req = 1; wr_req = 0; adr = $urandom; bus_ready = 0;
        @(posedge clk); #1;
        tests++; if (bus_valid !== 1) begin
            fails++; $display("FAIL mid_issue: valid=%b, want 1", bus_valid);
        end
        #2 reset = 0;
        #1;
        tests++; if (bus_valid !== 0) begin
            fails++; $display("FAIL mid_async: valid=%b, want 0", bus_valid);
        end
        @(posedge clk); #1;
        if (done) ndone_rst++;
        rd_req = 0; reset = 1;
        @(posedge clk); #1;
        if (done) ndone_rst++;
        exp_rdata = 0;
        tests++; if (ndone_rst !== 0 || stall !== 0 || rdata !== 0) begin
            fails++; $display("FAIL mid_nodone: done=%0d stall=%b rdata=%h, want 0 0 0", ndone_rst, stall, rdata);
        end
        r = $urandom;
        run_txn(1, 0, 32'h44, 0, r, 2, nv, ns, nd, we, a, wd, st);
        exp_rdata = r;
        tests++; if (nv !== 3 || ns !== 4 || nd !== 1 || rdata !== exp_rdata) begin
            fails++; $display("FAIL mid_after: valid=%0d stall=%0d done=%0d rdata=%h, want 3 4 1 %h", nv, ns, nd, rdata, exp_rdata);
        end
    endtask

    task automatic test_random;
        int nv, ns, nd, w; logic we, st, rd, wr; logic [31:0] a, wd, ea, ew, r;
        for (int i = 0; i < 24; i++) begin
            {rd, wr} = 2'($urandom_range(1, 3));
            ea = $urandom; ew = $urandom; r = $urandom; w = $urandom_range(0, 4);
            run_txn(rd, wr, ea, ew, r, w, nv, ns, nd, we, a, wd, st);
            if (!wr) exp_rdata = r;
            tests++; if (nv !== w + 1 || ns !== w + 2 || nd !== 1 || !st) begin
                fails++; $display("FAIL rand_timing[%0d]: valid=%0d stall=%0d done=%0d stable=%b, want %0d %0d 1 1", i, nv, ns, nd, st, w + 1, w + 2);
            end
            tests++; if (we !== wr || a !== ea || (wr && wd !== ew) || rdata !== exp_rdata || err !== 0) begin
                fails++; $display("FAIL rand_data[%0d]: we=%b adr=%h wd=%h rdata=%h err=%b, want %b %h %h %h 0", i, we, a, wd, rdata, err, wr, ea, ew, exp_rdata);
            end
        end
    endtask

`ifdef MEM_PORT_TIMEOUT_EN
    task automatic test_timeout;
        int nv, ns, nd; logic we, st; logic [31:0] a, wd, r;
        run_txn(1, 0, 32'h200, 0, $urandom, 1000, nv, ns, nd, we, a, wd, st);
        exp_rdata = 32'hFFFFFFFF;
        tests++; if (nv !== 15 || ns !== 16 || nd !== 1 || err !== 1 || rdata !== exp_rdata) begin
            fails++; $display("FAIL timeout: valid=%0d stall=%0d done=%0d err=%b rdata=%h, want 15 16 1 1 ffffffff", nv, ns, nd, err, rdata);
        end
        r = $urandom;
        run_txn(1, 0, 32'h204, 0, r, 0, nv, ns, nd, we, a, wd, st);
        exp_rdata = r;
        tests++; if (err !== 1 || rdata !== exp_rdata) begin
            fails++; $display("FAIL timeout_sticky: err=%b rdata=%h, want 1 %h", err, rdata, exp_rdata);
        end
        reset = 0; #2 reset = 1;
        @(posedge clk); #1;
        exp_rdata = 0;
        tests++; if (err !== 0) begin
            fails++; $display("FAIL timeout_clear: err=%b, want 0", err);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_read;
        test_write_wait;
        test_both;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef MEM_PORT_TIMEOUT_EN
        test_timeout;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
